// File: rtl/kronos_pkg.sv
// Shared types for the Kronos decode stage.
//   pipeIFID_t : fetch-to-decode payload (pc, raw instruction)
//   id_out_t   : registered decode result handed to execute
//   opcode_e   : RV32I major opcodes recognised by decode
package kronos_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } pipeIFID_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic        regwr;
    logic        illegal;
  } id_out_t;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_MISC   = 7'b0001111
  } opcode_e;

endpackage

// File: rtl/kronos_id.sv
// Kronos RV32I instruction decode stage.
// Accepts one fetched instruction per cycle over a valid/ready handshake,
// reads operands from the integrated 32x32 register file (with write-back
// bypass), decodes, and holds one decoded instruction for execute.
// Ports:
//   clk, rstz            clock, synchronous active-low reset
//   pipe_IFID            fetched {pc, ir}
//   pipe_in_vld/_rdy     fetch-side handshake
//   pipe_out_vld/_rdy    execute-side handshake
//   flush                drop held and incoming instruction
//   regwr_en/_sel/_data  architectural register write port (write-back)
//   id_*                 registered decode outputs
module kronos_id
  import kronos_pkg::*;
(
  input  logic        clk,
  input  logic        rstz,
  input  pipeIFID_t   pipe_IFID,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic        pipe_out_vld,
  input  logic        pipe_out_rdy,
  input  logic        flush,
  input  logic        regwr_en,
  input  logic [4:0]  regwr_sel,
  input  logic [31:0] regwr_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_ir,
  output logic [31:0] id_op1,
  output logic [31:0] id_op2,
  output logic [31:0] id_op3,
  output logic [31:0] id_imm,
  output logic [3:0]  id_aluop,
  output logic [4:0]  id_rd,
  output logic        id_regwr,
  output logic        id_illegal
);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] regfile_q [32];

  // NOTE: the register file is deliberately left out of reset; a reset
  // branch here would turn the storage array into 1024 resettable flops.
  always_ff @(posedge clk) begin
    if (regwr_en && (regwr_sel != 5'd0)) begin
      regfile_q[regwr_sel] <= regwr_data;
    end
  end

  logic [31:0] ir;
  logic [31:0] pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign ir  = pipe_IFID.ir;
  assign pc  = pipe_IFID.pc;
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  // A write landing this cycle is forwarded so the captured operand already
  // reflects it; x0 always reads zero.
  always_comb begin
    if (rs1 == 5'd0)                             rs1_val = '0;
    else if (regwr_en && (regwr_sel == rs1))     rs1_val = regwr_data;
    else                                         rs1_val = regfile_q[rs1];

    if (rs2 == 5'd0)                             rs2_val = '0;
    else if (regwr_en && (regwr_sel == rs2))     rs2_val = regwr_data;
    else                                         rs2_val = regfile_q[rs2];
  end

  // ---------------------------------------------------------------------------
  // Immediates
  // ---------------------------------------------------------------------------
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [2:0] funct3;
  logic [6:0] funct7;
  id_out_t    dec;

  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  // NOTE: every field gets a default before the case so no path through
  // this block can leave a value unassigned (which would infer a latch).
  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.ir      = ir;
    dec.op3     = rs2_val;
    dec.rd      = ir[11:7];

    case (ir[6:0])
      OPC_LUI: begin
        dec.op2   = imm_u;
        dec.imm   = imm_u;
        dec.regwr = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1   = pc;
        dec.op2   = imm_u;
        dec.imm   = imm_u;
        dec.regwr = 1'b1;
      end
      OPC_JAL: begin
        dec.op1   = pc;
        dec.op2   = 32'd4;
        dec.imm   = imm_j;
        dec.regwr = 1'b1;
      end
      OPC_JALR: begin
        dec.op1     = pc;
        dec.op2     = 32'd4;
        dec.imm     = imm_i;
        dec.regwr   = 1'b1;
        dec.illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.op1     = rs1_val;
        dec.op2     = rs2_val;
        dec.imm     = imm_b;
        dec.aluop   = {1'b0, funct3};
        dec.illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        dec.op1     = rs1_val;
        dec.op2     = imm_i;
        dec.imm     = imm_i;
        dec.regwr   = 1'b1;
        dec.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.op1     = rs1_val;
        dec.op2     = imm_s;
        dec.imm     = imm_s;
        dec.illegal = (funct3 >= 3'b011);
      end
      OPC_OPIMM: begin
        dec.op1   = rs1_val;
        dec.op2   = imm_i;
        dec.imm   = imm_i;
        dec.regwr = 1'b1;
        // Only the shift-right form uses ir[30] to select arithmetic shift.
        dec.aluop = {(funct3 == 3'b101) ? ir[30] : 1'b0, funct3};
        if (funct3 == 3'b001)
          dec.illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          dec.illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        dec.op1     = rs1_val;
        dec.op2     = rs2_val;
        dec.regwr   = 1'b1;
        dec.aluop   = {ir[30], funct3};
        dec.illegal = !((funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_MISC: begin
        // FENCE is a no-op in this core.
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase

    if (dec.illegal || (dec.rd == 5'd0)) begin
      dec.regwr = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline register
  // ---------------------------------------------------------------------------
  logic    out_vld_q;
  logic    out_vld_d;
  id_out_t id_q;
  id_out_t id_d;

  assign pipe_in_rdy = ~out_vld_q | pipe_out_rdy;

  // flush wins over capture; the held data is simply not marked valid.
  always_comb begin
    out_vld_d = out_vld_q;
    id_d      = id_q;
    if (flush) begin
      out_vld_d = 1'b0;
    end else if (pipe_in_vld && pipe_in_rdy) begin
      out_vld_d = 1'b1;
      id_d      = dec;
    end else if (out_vld_q && pipe_out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next-state value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      out_vld_q <= 1'b0;
      id_q      <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      id_q      <= id_d;
    end
  end

  assign pipe_out_vld = out_vld_q;
  assign id_pc        = id_q.pc;
  assign id_ir        = id_q.ir;
  assign id_op1       = id_q.op1;
  assign id_op2       = id_q.op2;
  assign id_op3       = id_q.op3;
  assign id_imm       = id_q.imm;
  assign id_aluop     = id_q.aluop;
  assign id_rd        = id_q.rd;
  assign id_regwr     = id_q.regwr;
  assign id_illegal   = id_q.illegal;

endmodule

// File: tb/tb_kronos_id.sv
// Self-checking bench for kronos_id: directed scenarios followed by random
// traffic, all compared against a behavioural model of the decode stage.
module tb_kronos_id;
  import kronos_pkg::*;

  logic        clk = 1'b0;
  logic        rstz;
  pipeIFID_t   pipe_IFID;
  logic        pipe_in_vld;
  logic        pipe_in_rdy;
  logic        pipe_out_vld;
  logic        pipe_out_rdy;
  logic        flush;
  logic        regwr_en;
  logic [4:0]  regwr_sel;
  logic [31:0] regwr_data;
  logic [31:0] id_pc, id_ir, id_op1, id_op2, id_op3, id_imm;
  logic [3:0]  id_aluop;
  logic [4:0]  id_rd;
  logic        id_regwr, id_illegal;

  kronos_id dut (
    .clk          (clk),
    .rstz         (rstz),
    .pipe_IFID    (pipe_IFID),
    .pipe_in_vld  (pipe_in_vld),
    .pipe_in_rdy  (pipe_in_rdy),
    .pipe_out_vld (pipe_out_vld),
    .pipe_out_rdy (pipe_out_rdy),
    .flush        (flush),
    .regwr_en     (regwr_en),
    .regwr_sel    (regwr_sel),
    .regwr_data   (regwr_data),
    .id_pc        (id_pc),
    .id_ir        (id_ir),
    .id_op1       (id_op1),
    .id_op2       (id_op2),
    .id_op3       (id_op3),
    .id_imm       (id_imm),
    .id_aluop     (id_aluop),
    .id_rd        (id_rd),
    .id_regwr     (id_regwr),
    .id_illegal   (id_illegal)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected decode result; the chk_* flags mark fields whose value is
  // defined for that instruction class.
  typedef struct {
    logic [31:0] pc, ir, op1, op2, op3, imm;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic        regwr, illegal;
    bit          chk_ops, chk_alu, chk_imm;
  } exp_t;

  logic [31:0] rf_m [32];
  bit          m_vld;
  exp_t        m_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] read_m(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (regwr_en && regwr_sel == idx) return regwr_data;
    return rf_m[idx];
  endfunction

  function automatic exp_t model_decode(input logic [31:0] pc, input logic [31:0] ir);
    exp_t e;
    logic [2:0]  f3 = ir[14:12];
    logic [6:0]  f7 = ir[31:25];
    logic [31:0] r1 = read_m(ir[19:15]);
    logic [31:0] r2 = read_m(ir[24:20]);
    int i_imm = int'($signed(ir[31:20]));
    int s_imm = int'($signed({ir[31:25], ir[11:7]}));
    int b_imm = int'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    int j_imm = int'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
    int u_imm = int'(ir[31:12]) * 4096;
    e = '{pc: pc, ir: ir, op1: 0, op2: 0, op3: r2, imm: 0, aluop: 0, rd: ir[11:7],
          regwr: 0, illegal: 0, chk_ops: 1, chk_alu: 1, chk_imm: 0};
    case (ir[6:0])
      7'b0110111: begin e.op2 = u_imm; e.regwr = 1; end
      7'b0010111: begin e.op1 = pc; e.op2 = u_imm; e.regwr = 1; end
      7'b1101111: begin e.op1 = pc; e.op2 = 4; e.imm = j_imm; e.chk_imm = 1; e.regwr = 1; end
      7'b1100111: begin
        e.op1 = pc; e.op2 = 4; e.imm = i_imm; e.chk_imm = 1; e.regwr = 1;
        e.chk_alu = 0; e.illegal = (f3 != 0);
      end
      7'b1100011: begin
        e.op1 = r1; e.op2 = r2; e.imm = b_imm; e.chk_imm = 1; e.aluop = {1'b0, f3};
        e.illegal = (f3 == 2 || f3 == 3);
      end
      7'b0000011: begin e.op1 = r1; e.op2 = i_imm; e.regwr = 1; e.illegal = (f3 == 3 || f3 >= 6); end
      7'b0100011: begin e.op1 = r1; e.op2 = s_imm; e.illegal = (f3 >= 3); end
      7'b0010011: begin
        e.op1 = r1; e.op2 = i_imm; e.regwr = 1;
        e.aluop = {(f3 == 5) ? ir[30] : 1'b0, f3};
        e.illegal = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
      end
      7'b0110011: begin
        e.op1 = r1; e.op2 = r2; e.regwr = 1; e.aluop = {ir[30], f3};
        e.illegal = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'b0001111: ;
      default: e.illegal = 1;
    endcase
    if (e.illegal) begin e.regwr = 0; e.chk_ops = 0; e.chk_alu = 0; e.chk_imm = 0; end
    if (e.rd == 0) e.regwr = 0;
    return e;
  endfunction

  task automatic compare_out(input string tag);
    check({tag, ".pc"},      id_pc,              m_out.pc);
    check({tag, ".ir"},      id_ir,              m_out.ir);
    check({tag, ".op3"},     id_op3,             m_out.op3);
    check({tag, ".rd"},      32'(id_rd),         32'(m_out.rd));
    check({tag, ".regwr"},   32'(id_regwr),      32'(m_out.regwr));
    check({tag, ".illegal"}, 32'(id_illegal),    32'(m_out.illegal));
    if (m_out.chk_ops) begin
      check({tag, ".op1"}, id_op1, m_out.op1);
      check({tag, ".op2"}, id_op2, m_out.op2);
    end
    if (m_out.chk_alu) check({tag, ".aluop"}, 32'(id_aluop), 32'(m_out.aluop));
    if (m_out.chk_imm) check({tag, ".imm"},   id_imm,        m_out.imm);
  endtask

  // One clock cycle: inputs are already driven; advance the model, clock the
  // DUT, and compare just after the edge.
  task automatic tick(input string tag);
    bit in_rdy_m;
    #1;
    in_rdy_m = !m_vld || pipe_out_rdy;
    check({tag, ".in_rdy"}, 32'(pipe_in_rdy), 32'(in_rdy_m));
    if (!rstz) begin
      m_vld = 0;
      m_out = '{default: 0};
    end else if (flush) begin
      m_vld = 0;
    end else if (pipe_in_vld && in_rdy_m) begin
      m_out = model_decode(pipe_IFID.pc, pipe_IFID.ir);
      m_vld = 1;
    end else if (m_vld && pipe_out_rdy) begin
      m_vld = 0;
    end
    if (regwr_en && regwr_sel != 0) rf_m[regwr_sel] = regwr_data;
    @(posedge clk);
    #1;
    check({tag, ".out_vld"}, 32'(pipe_out_vld), 32'(m_vld));
    if (m_vld) compare_out(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".pc"},      id_pc,           0);
    check({tag, ".ir"},      id_ir,           0);
    check({tag, ".op1"},     id_op1,          0);
    check({tag, ".op2"},     id_op2,          0);
    check({tag, ".op3"},     id_op3,          0);
    check({tag, ".imm"},     id_imm,          0);
    check({tag, ".aluop"},   32'(id_aluop),   0);
    check({tag, ".rd"},      32'(id_rd),      0);
    check({tag, ".regwr"},   32'(id_regwr),   0);
    check({tag, ".illegal"}, 32'(id_illegal), 0);
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] ir);
    pipe_IFID.pc = pc;
    pipe_IFID.ir = ir;
    pipe_in_vld  = 1;
  endtask

  task automatic drain();
    pipe_in_vld  = 0;
    pipe_out_rdy = 1;
    flush        = 0;
    regwr_en     = 0;
    tick("drain");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    int k = $urandom_range(0, 11);
    if (k < 11) r[6:0] = opcs[k];
    if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0)
      r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return r;
  endfunction

  initial begin
    logic [31:0] seq [8];
    int idx;
    bit acc;

    rstz = 0; pipe_in_vld = 0; pipe_out_rdy = 1; flush = 0;
    regwr_en = 0; regwr_sel = 0; regwr_data = 0;
    pipe_IFID = '0;
    m_vld = 0;
    m_out = '{default: 0};
    rf_m  = '{default: 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_vld", 32'(pipe_out_vld), 0);
    check("rst.in_rdy",  32'(pipe_in_rdy),  1);
    check_zero("rst");
    rstz = 1;

    // Load known values into x1..x31
    for (int i = 1; i < 32; i++) begin
      regwr_en = 1; regwr_sel = 5'(i); regwr_data = $urandom;
      tick("preload");
    end
    regwr_en = 0;

    // ADDI x1,x0,5
    present(32'h0, 32'h0050_0093);
    tick("addi");
    check("addi.vld",   32'(pipe_out_vld), 1);
    check("addi.op1",   id_op1, 0);
    check("addi.op2",   id_op2, 5);
    check("addi.aluop", 32'(id_aluop), 0);
    check("addi.rd",    32'(id_rd), 1);
    check("addi.regwr", 32'(id_regwr), 1);
    drain();

    // Write-back bypass: x2 written in the same cycle ADD x3,x2,x2 decodes
    regwr_en = 1; regwr_sel = 2; regwr_data = 32'h1234;
    present(32'h4, 32'h0021_01B3);
    tick("bypass");
    check("bypass.op1", id_op1, 32'h1234);
    check("bypass.op2", id_op2, 32'h1234);
    drain();

    // BEQ x1,x2,-8 at 0x100
    present(32'h100, 32'hFE20_8CE3);
    tick("beq");
    check("beq.imm",   id_imm, 32'hFFFF_FFF8);
    check("beq.regwr", 32'(id_regwr), 0);
    check("beq.op2",   id_op2, 32'h1234);
    drain();

    // SRAI x5,x5,3
    present(32'h8, 32'h4032_D293);
    tick("srai");
    check("srai.aluop", 32'(id_aluop), 32'hD);
    check("srai.op2lo", 32'(id_op2[11:0]), 32'h403);
    drain();

    // SLLI with funct7=20h
    present(32'hC, 32'h4010_9093);
    tick("slli_bad");
    check("slli_bad.illegal", 32'(id_illegal), 1);
    check("slli_bad.regwr",   32'(id_regwr), 0);
    drain();

    // ECALL
    present(32'h10, 32'h0000_0073);
    tick("ecall");
    check("ecall.illegal", 32'(id_illegal), 1);
    drain();

    // Back-to-back with pipe_out_rdy pattern 1,0,0,1
    for (int i = 0; i < 8; i++) seq[i] = rand_instr();
    idx = 0;
    for (int c = 0; c < 64 && idx < 8; c++) begin
      present(32'h200 + 32'(idx * 4), seq[idx]);
      pipe_out_rdy = (c % 4 == 0) || (c % 4 == 3);
      acc = !m_vld || pipe_out_rdy;
      tick("b2b");
      if (acc) idx++;
    end
    check("b2b.count", 32'(idx), 8);
    drain();

    // Flush while holding
    present(32'h300, 32'h0050_0093);
    pipe_out_rdy = 0;
    tick("fl_hold");
    tick("fl_stall");
    present(32'h304, 32'h0021_01B3);
    flush = 1;
    tick("flush");
    check("flush.vld", 32'(pipe_out_vld), 0);
    flush = 0; pipe_in_vld = 0; pipe_out_rdy = 1;
    tick("post_flush");
    check("post_flush.vld", 32'(pipe_out_vld), 0);

    // Reset mid-stream
    present(32'h400, 32'h0032_8293);
    pipe_out_rdy = 0;
    tick("mid_hold");
    rstz = 0;
    present(32'h404, 32'h0050_0093);
    tick("mid_rst");
    check_zero("mid_rst");
    rstz = 1; pipe_out_rdy = 1;
    present(32'h408, 32'h0021_01B3);
    tick("after_rst");
    check("after_rst.vld", 32'(pipe_out_vld), 1);
    drain();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      present($urandom & 32'hFFFF_FFFC, rand_instr());
      pipe_in_vld  = ($urandom_range(0, 3) != 0);
      pipe_out_rdy = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 9) == 0);
      regwr_en     = ($urandom_range(0, 1) == 1);
      regwr_sel    = 5'($urandom);
      regwr_data   = $urandom;
      tick("rand");
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
